// File: rtl/s2p_pkg.sv
// Shared types and default parameters for the four-lane serial-to-parallel deserializer.
package s2p_pkg;

  localparam int unsigned S2P_LANES    = 4;
  localparam int unsigned S2P_BYTE     = 8;
  localparam logic [7:0]  S2P_SYNC     = 8'hBC;
  localparam int unsigned S2P_LOCK_CNT = 2;

  typedef enum logic [1:0] {
    StSearch,
    StAlign,
    StLocked
  } s2p_state_e;

endpackage

// File: rtl/s2p_deser_if.sv
// Serial input and parallel output bundle of the deserializer.
interface s2p_deser_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned BYTE  = 8
);

  logic                    ENB;
  logic [LANES-1:0]        data_in;
  logic [BYTE-1:0]         Q0;
  logic [BYTE-1:0]         Q1;
  logic [BYTE-1:0]         Q2;
  logic [BYTE-1:0]         Q3;
  logic [LANES*BYTE-1:0]   data_out;
  logic                    valid;
  logic                    locked;
  logic [2:0]              bit_cnt;

  modport master (
    output ENB, data_in,
    input  Q0, Q1, Q2, Q3, data_out, valid, locked, bit_cnt
  );

  modport slave (
    input  ENB, data_in,
    output Q0, Q1, Q2, Q3, data_out, valid, locked, bit_cnt
  );

endinterface

// File: rtl/s2p_lane.sv
// One serial lane: MSB-first shift register exposing the value it will hold after this edge.
module s2p_lane #(
  parameter int unsigned BYTE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enb,
  input  logic            din,
  output logic [BYTE-1:0] next_byte
);

  logic [BYTE-1:0] sr_q;

  assign next_byte = {sr_q[BYTE-2:0], din};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (enb) begin
      sr_q <= next_byte;
    end
  end

endmodule

// File: rtl/s2p_deser.sv
// Four-lane deserializer: aligns on lane-0 sync bytes, locks, then delivers non-idle words.
module s2p_deser
  import s2p_pkg::*;
#(
  parameter int unsigned LANES    = S2P_LANES,
  parameter int unsigned BYTE     = S2P_BYTE,
  parameter logic [7:0]  SYNC     = S2P_SYNC,
  parameter int unsigned LOCK_CNT = S2P_LOCK_CNT
) (
  input  logic       CLK,
  input  logic       reset,
  s2p_deser_if.slave bus
);

  localparam int unsigned MatchW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  logic [BYTE-1:0]   lane_next [LANES];
  logic [BYTE-1:0]   q_q       [LANES];
  s2p_state_e        state_q;
  logic [2:0]        bit_cnt_q;
  logic [MatchW-1:0] match_q;
  logic              valid_q;
  logic              locked_q;
  logic              all_sync;
  logic              boundary;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    s2p_lane #(
      .BYTE (BYTE)
    ) u_lane (
      .clk       (CLK),
      .rst       (reset),
      .enb       (bus.ENB),
      .din       (bus.data_in[i]),
      .next_byte (lane_next[i])
    );
  end

  always_comb begin
    all_sync = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (lane_next[i] != SYNC) all_sync = 1'b0;
    end
  end

  assign boundary = (bit_cnt_q == 3'd7);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= StSearch;
      bit_cnt_q <= '0;
      match_q   <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      for (int i = 0; i < LANES; i++) q_q[i] <= '0;
    end else begin
      // valid is a single-cycle pulse regardless of ENB
      valid_q <= 1'b0;
      if (bus.ENB) begin
        case (state_q)
          StSearch: begin
            if (lane_next[0] == SYNC) begin
              bit_cnt_q <= '0;
              match_q   <= MatchW'(1);
              if (LOCK_CNT <= 1) begin
                state_q  <= StLocked;
                locked_q <= 1'b1;
              end else begin
                state_q <= StAlign;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
          StAlign: begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (boundary) begin
              if (lane_next[0] == SYNC) begin
                match_q <= match_q + MatchW'(1);
                if (int'(match_q) + 1 >= int'(LOCK_CNT)) begin
                  state_q  <= StLocked;
                  locked_q <= 1'b1;
                end
              end else begin
                state_q <= StSearch;
                match_q <= '0;
              end
            end
          end
          StLocked: begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (boundary && !all_sync) begin
              for (int i = 0; i < LANES; i++) q_q[i] <= lane_next[i];
              valid_q <= 1'b1;
            end
          end
          default: state_q <= StSearch;
        endcase
      end
    end
  end

  assign bus.Q0      = q_q[0];
  assign bus.Q1      = q_q[1];
  assign bus.Q2      = q_q[2];
  assign bus.Q3      = q_q[3];
  assign bus.valid   = valid_q & bus.ENB;
  assign bus.locked  = locked_q;
  assign bus.bit_cnt = bit_cnt_q;

  always_comb begin
    bus.data_out = '0;
    for (int i = 0; i < LANES; i++) bus.data_out[i*BYTE +: BYTE] = q_q[i];
  end

endmodule

// File: tb/tb_s2p_deser.sv
// Bench for s2p_deser: vector table, corner-case sequences, and random streams vs a stream model.
module tb_s2p_deser;
  import s2p_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  s2p_deser_if bus ();

  s2p_deser dut (
    .CLK   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] word;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_locked;
  } vec_t;

  typedef struct {
    logic       enb;
    logic [3:0] bits;
  } cyc_t;

  vec_t tbl[6];
  cyc_t cq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] word_bits(input logic [31:0] w, input int b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = w[i*8 + 7 - b];
    return r;
  endfunction

  task automatic drive(input logic enb, input logic [3:0] bits);
    @(negedge clk);
    bus.ENB     = enb;
    bus.data_in = bits;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.ENB     = 1'b0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_state", {27'd0, bus.valid, bus.locked, bus.bit_cnt, bus.data_out},
        64'd0);
  endtask

  task automatic send_word(input vec_t v, input string tag);
    for (int b = 0; b < 8; b++) begin
      drive(1'b1, word_bits(v.word, b));
      if (b == 7) begin
        chk({tag, "_end"}, {30'd0, bus.valid, bus.locked, bus.data_out},
            {30'd0, v.exp_valid, v.exp_locked, v.exp_data});
      end else begin
        chk({tag, "_mid_valid"}, {63'd0, bus.valid}, 64'd0);
      end
    end
  endtask

  task automatic run_table(input string tag);
    for (int t = 0; t < 6; t++) send_word(tbl[t], tag);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 8; b++) begin
      if ($urandom_range(0, 7) == 0) cq.push_back('{1'b0, 4'($urandom)});
      cq.push_back('{1'b1, word_bits(w, b)});
    end
  endtask

  function automatic logic [7:0] rand_byte();
    return ($urandom_range(0, 2) == 0) ? S2P_SYNC : 8'($urandom);
  endfunction

  task automatic build_stream();
    logic [31:0] w;
    cq.delete();
    for (int p = 0; p < int'($urandom_range(0, 7)); p++) cq.push_back('{1'b1, 4'($urandom)});
    for (int s = 0; s < 2; s++) begin
      w = {rand_byte(), rand_byte(), rand_byte(), S2P_SYNC};
      if (s == 1 && $urandom_range(0, 3) == 0) w[7:0] = 8'($urandom);
      push_word(w);
    end
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 3) == 0) w = {4{S2P_SYNC}};
      else w = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
      push_word(w);
    end
  endtask

  // Model works on the sequence of enabled bits: byte windows and positions relative to the
  // bit where lane 0 first showed a sync byte.
  task automatic run_random();
    int          k, anchor, mstate, cnt;
    logic [7:0]  win [4];
    logic [31:0] exp_data;
    logic        exp_valid, all_idle;
    logic [2:0]  exp_bc;
    k = -1; anchor = -1; mstate = 0; cnt = 0; exp_data = '0;
    for (int i = 0; i < 4; i++) win[i] = '0;
    do_reset();
    foreach (cq[c]) begin
      drive(cq[c].enb, cq[c].bits);
      exp_valid = 1'b0;
      if (cq[c].enb) begin
        k++;
        for (int i = 0; i < 4; i++) win[i] = {win[i][6:0], cq[c].bits[i]};
        if (mstate == 0) begin
          if (win[0] == S2P_SYNC) begin
            anchor = k; cnt = 1; mstate = 1;
          end
        end else if ((k - anchor) % 8 == 0) begin
          if (mstate == 1) begin
            if (win[0] == S2P_SYNC) begin
              cnt++;
              if (cnt >= int'(S2P_LOCK_CNT)) mstate = 2;
            end else begin
              mstate = 0;
            end
          end else begin
            all_idle = 1'b1;
            for (int i = 0; i < 4; i++) if (win[i] != S2P_SYNC) all_idle = 1'b0;
            if (!all_idle) begin
              exp_data  = {win[3], win[2], win[1], win[0]};
              exp_valid = 1'b1;
            end
          end
        end
      end
      exp_bc = (anchor < 0) ? 3'((k + 1) % 8) : 3'((k - anchor) % 8);
      chk("random", {27'd0, bus.valid, bus.locked, bus.bit_cnt, bus.data_out},
          {27'd0, exp_valid, (mstate == 2), exp_bc, exp_data});
    end
  endtask

  initial begin
    tbl[0] = '{32'hBCBCBCBC, 1'b0, 32'h00000000, 1'b0};
    tbl[1] = '{32'hBCBCBCBC, 1'b0, 32'h00000000, 1'b1};
    tbl[2] = '{32'h44332211, 1'b1, 32'h44332211, 1'b1};
    tbl[3] = '{32'hBCBCBCBC, 1'b0, 32'h44332211, 1'b1};
    tbl[4] = '{32'h010101BC, 1'b1, 32'h010101BC, 1'b1};
    tbl[5] = '{32'h5A0000BC, 1'b1, 32'h5A0000BC, 1'b1};

    // Aligned stream, then an asynchronous reset three bits into a data word.
    do_reset();
    run_table("aligned");
    for (int b = 0; b < 3; b++) drive(1'b1, word_bits(32'h77665544, b));
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {27'd0, bus.valid, bus.locked, bus.bit_cnt, bus.data_out}, 64'd0);
    chk("async_reset_q", {32'd0, bus.Q3, bus.Q2, bus.Q1, bus.Q0}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Misaligned: three stray bits ahead of the same stream.
    for (int b = 0; b < 3; b++) begin
      drive(1'b1, (b == 1) ? 4'h0 : 4'hF);
      chk("misalign_prefix", {62'd0, bus.valid, bus.locked}, 64'd0);
    end
    run_table("misaligned");

    // Failed lock: sync then a non-sync byte on lane 0, then a clean stream must lock.
    do_reset();
    send_word('{32'h000000BC, 1'b0, 32'h0, 1'b0}, "fail_sync");
    send_word('{32'h00000000, 1'b0, 32'h0, 1'b0}, "fail_break");
    send_word('{32'h00000000, 1'b0, 32'h0, 1'b0}, "fail_after");
    run_table("relock");

    // ENB gap of five cycles inside a data word.
    do_reset();
    send_word(tbl[0], "gap_sync0");
    send_word(tbl[1], "gap_sync1");
    for (int b = 0; b < 8; b++) begin
      drive(1'b1, word_bits(32'h44332211, b));
      if (b == 2) begin
        for (int g = 0; g < 5; g++) begin
          drive(1'b0, 4'($urandom));
          chk("gap_hold", {60'd0, bus.valid, bus.bit_cnt}, {60'd0, 1'b0, 3'd3});
        end
      end
    end
    chk("gap_word", {31'd0, bus.valid, bus.data_out}, {31'd0, 1'b1, 32'h44332211});

    for (int r = 0; r < 20; r++) begin
      build_stream();
      run_random();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/s2p_deser.md
# s2p_deser

Four-lane serial-to-parallel deserializer that sits directly downstream of the parallel-to-serial stage. Each lane carries one bit per CLK, MSB first. The block bit-aligns to a sync byte on lane 0 and locks after consecutive sync bytes. Once locked, it rebuilds the 32-bit word as four bytes Q0..Q3 and emits a one-cycle valid pulse per non-idle word.

## Interface

Parameters:
- LANES, 4, number of serial lanes (one byte per lane per word)
- BYTE, 8, bits per lane per word
- SYNC, 8'hBC, alignment/idle byte
- LOCK_CNT, 2, consecutive sync bytes on lane 0 required for lock

Ports:
- CLK  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- ENB  input  1  enable; when low, all state holds and valid is forced 0
- data_in  input  LANES  one serial bit per lane; data_in[i] is lane i
- Q0, Q1, Q2, Q3  output  8 each  last delivered byte of lanes 0..3
- data_out  output  32  {Q3,Q2,Q1,Q0}
- valid  output  1  one-cycle pulse: new word on Q*/data_out
- locked  output  1  high in LOCKED state
- bit_cnt  output  3  current bit position within byte (0 = first bit)

## Operation

- Per-lane shift register: on each CLK edge with ENB=1, next = {sr[6:0], data_in[i]}. Shifting runs in every state.
- Byte boundary: bit_cnt==7 with ENB=1; bit_cnt wraps 7->0. The completed byte is the next-value of the shift register.
- States (held in s2p_pkg enum):
  - SEARCH (reset state): on every enabled edge, if lane-0 next-value==SYNC, go to ALIGN, set bit_cnt:=0 and match_cnt:=1. Otherwise bit_cnt free-runs.
  - ALIGN: at each byte boundary, if the lane-0 byte==SYNC, match_cnt++; when match_cnt reaches LOCK_CNT, go to LOCKED. If the lane-0 byte!=SYNC, go to SEARCH and set match_cnt:=0. No valid is produced in ALIGN.
  - LOCKED: at each byte boundary, if all four lane bytes==SYNC the word is idle: Q* hold and valid=0. Otherwise Q0..Q3 <= lane bytes and valid=1 for one cycle. Lock is held until reset.
- Sync bytes on lane 0 with any non-SYNC byte on another lane are data and are delivered.
- Reset values: Q0..Q3=0, data_out=0, valid=0, locked=0, bit_cnt=0, match_cnt=0, shift registers=0, state=SEARCH.
- Reset mid-operation: all of the above values take effect asynchronously, without a clock edge. Partial bytes are discarded.
- ENB low mid-byte: shift registers, bit_cnt and state freeze. The stream resumes seamlessly when ENB returns. A boundary is never counted while ENB=0.

## Timing

- Q*, data_out and valid are registered on the edge that samples a byte's 8th bit. valid is high for exactly the following cycle.
- locked rises on the edge that samples the last bit of the LOCK_CNT-th consecutive sync byte. With default parameters and an aligned stream, that is the 16th bit.
- First deliverable word after lock: valid one cycle after its 8th bit, i.e. after bit 24 of the stream when the stream starts aligned.
- Back-to-back non-idle words produce valid pulses every 8 enabled cycles. There is no backpressure.

## Structure

- s2p_pkg: state enum (SEARCH, ALIGN, LOCKED), SYNC, LANES, BYTE, LOCK_CNT defaults.
- Sub-module s2p_lane: 8-bit shift register plus next-byte output, instantiated LANES times.
- Top level holds the FSM, bit_cnt, match_cnt and output registers.

## Test plan

- Async reset: assert reset mid-byte between clock edges -> all outputs 0 immediately, locked=0; after release, the block re-searches from SEARCH.
- Aligned lock: 0xBC,0xBC on all lanes, then lane bytes 0x11/0x22/0x33/0x44 -> locked rises at bit 16; valid one cycle after bit 24; data_out=32'h44332211.
- Misaligned: prefix bits 1,0,1 then the same stream -> identical outputs, shifted 3 cycles later.
- Failed lock: lane 0 sends 0xBC then 0x00 -> state returns to SEARCH, locked stays 0, no valid.
- ENB gap: ENB low for 5 cycles mid-byte of a data word -> same data_out as the uninterrupted run; valid never high while ENB=0.
- Idle handling in LOCKED: all lanes 0xBC -> no valid, Q* hold; then lane0=0xBC with lanes1..3=0x01 -> valid=1, data_out=32'h010101BC.
